fft_bfly: RTL and testbench

FFT_BFLY -- requirements
Module: fft_bfly

---
 rtl/fft_bfly_if.sv | 35 +++
 rtl/fft_bfly.sv | 155 +++++++++++++++
 tb/tb_fft_bfly.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fft_bfly_if.sv
// Butterfly operand/result bundle: operands, twiddle, write-back addresses in;
// results, RAM write enables, done and overflow status out.
interface fft_bfly_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic                 in_valid;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [DW-1:0] w_re, w_im;
  logic [AW-1:0]        addrA_in, addrB_in;
  logic                 wr_sel;
  logic                 last_in;
  logic                 scale;
  logic                 ovf_clr;

  logic signed [DW-1:0] x_re, x_im, y_re, y_im;
  logic [AW-1:0]        addrA_out, addrB_out;
  logic                 we_ram1, we_ram2;
  logic                 done_out;
  logic                 ovf;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im,
           addrA_in, addrB_in, wr_sel, last_in, scale, ovf_clr,
    input  x_re, x_im, y_re, y_im, addrA_out, addrB_out,
           we_ram1, we_ram2, done_out, ovf
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im,
           addrA_in, addrB_in, wr_sel, last_in, scale, ovf_clr,
    output x_re, x_im, y_re, y_im, addrA_out, addrB_out,
           we_ram1, we_ram2, done_out, ovf
  );
endinterface

// File: rtl/fft_bfly.sv
// Radix-2 DIT butterfly X = A + W*B, Y = A - W*B: three pipeline stages with
// rounding, optional halving, saturation and a sticky overflow flag.
module fft_bfly #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  fft_bfly_if.slave   bus
);

  // Round-half-up of the Q(2*DW-2) product back to Q(DW-1) scale.
  function automatic logic signed [DW+1:0] round_shift(input logic signed [2*DW:0] p);
    logic signed [2*DW:0] half;
    logic signed [2*DW:0] sh;
    half         = '0;
    half[DW-2]   = 1'b1;
    sh           = (p + half) >>> (DW-1);
    return sh[DW+1:0];
  endfunction

  function automatic logic signed [DW+2:0] halve(input logic signed [DW+2:0] v,
                                                 input logic en);
    return en ? ((v + (DW+3)'(1)) >>> 1) : v;
  endfunction

  function automatic logic fits(input logic signed [DW+2:0] v);
    return (v[DW+2:DW-1] == '0) || (v[DW+2:DW-1] == '1);
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [DW+2:0] v);
    if (fits(v))
      return v[DW-1:0];
    else if (v[DW+2])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  logic                 vld_p0, vld_p1;
  logic signed [DW-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0, w_re_p0, w_im_p0;
  logic [AW-1:0]        addr_a_p0, addr_b_p0;
  logic                 scale_p0, wr_sel_p0, last_p0;

  logic signed [DW-1:0]   a_re_p1, a_im_p1;
  logic signed [2*DW-1:0] rr_p1, ii_p1, ri_p1, ir_p1;
  logic [AW-1:0]          addr_a_p1, addr_b_p1;
  logic                   scale_p1, wr_sel_p1, last_p1;

  logic signed [DW-1:0] x_re_p2, x_im_p2, y_re_p2, y_im_p2;
  logic [AW-1:0]        addr_a_p2, addr_b_p2;
  logic                 we1_p2, we2_p2, done_p2, sat_p2, ovf_p2;

  logic signed [2*DW:0] p_re, p_im;
  logic signed [DW+1:0] t_re, t_im;
  logic signed [DW+2:0] xr_s, xi_s, yr_s, yi_s;
  logic                 sat_any;

  // Stage 0: capture operands; bubbles leave the registers untouched
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      a_re_p0   <= bus.a_re;
      a_im_p0   <= bus.a_im;
      b_re_p0   <= bus.b_re;
      b_im_p0   <= bus.b_im;
      w_re_p0   <= bus.w_re;
      w_im_p0   <= bus.w_im;
      addr_a_p0 <= bus.addrA_in;
      addr_b_p0 <= bus.addrB_in;
      scale_p0  <= bus.scale;
      wr_sel_p0 <= bus.wr_sel;
      last_p0   <= bus.last_in;
    end
  end

  // Stage 1: four full-width partial products
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      rr_p1     <= b_re_p0 * w_re_p0;
      ii_p1     <= b_im_p0 * w_im_p0;
      ri_p1     <= b_re_p0 * w_im_p0;
      ir_p1     <= b_im_p0 * w_re_p0;
      a_re_p1   <= a_re_p0;
      a_im_p1   <= a_im_p0;
      addr_a_p1 <= addr_a_p0;
      addr_b_p1 <= addr_b_p0;
      scale_p1  <= scale_p0;
      wr_sel_p1 <= wr_sel_p0;
      last_p1   <= last_p0;
    end
  end

  always_comb begin
    p_re    = (2*DW+1)'(rr_p1) - (2*DW+1)'(ii_p1);
    p_im    = (2*DW+1)'(ri_p1) + (2*DW+1)'(ir_p1);
    t_re    = round_shift(p_re);
    t_im    = round_shift(p_im);
    xr_s    = halve((DW+3)'(a_re_p1) + (DW+3)'(t_re), scale_p1);
    xi_s    = halve((DW+3)'(a_im_p1) + (DW+3)'(t_im), scale_p1);
    yr_s    = halve((DW+3)'(a_re_p1) - (DW+3)'(t_re), scale_p1);
    yi_s    = halve((DW+3)'(a_im_p1) - (DW+3)'(t_im), scale_p1);
    sat_any = !fits(xr_s) || !fits(xi_s) || !fits(yr_s) || !fits(yi_s);
  end

  // Stage 2: registered results; outputs hold between valid writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      x_re_p2   <= '0;
      x_im_p2   <= '0;
      y_re_p2   <= '0;
      y_im_p2   <= '0;
      addr_a_p2 <= '0;
      addr_b_p2 <= '0;
      we1_p2    <= 1'b0;
      we2_p2    <= 1'b0;
      done_p2   <= 1'b0;
      sat_p2    <= 1'b0;
      ovf_p2    <= 1'b0;
    end else begin
      vld_p0  <= bus.in_valid;
      vld_p1  <= vld_p0;
      we1_p2  <= vld_p1 & ~wr_sel_p1;
      we2_p2  <= vld_p1 &  wr_sel_p1;
      done_p2 <= vld_p1 & last_p1;
      sat_p2  <= vld_p1 & sat_any;
      if (vld_p1) begin
        x_re_p2   <= saturate(xr_s);
        x_im_p2   <= saturate(xi_s);
        y_re_p2   <= saturate(yr_s);
        y_im_p2   <= saturate(yi_s);
        addr_a_p2 <= addr_a_p1;
        addr_b_p2 <= addr_b_p1;
      end
      // A new saturation outranks a clear in the same cycle
      if (sat_p2)
        ovf_p2 <= 1'b1;
      else if (bus.ovf_clr)
        ovf_p2 <= 1'b0;
    end
  end

  assign bus.x_re      = x_re_p2;
  assign bus.x_im      = x_im_p2;
  assign bus.y_re      = y_re_p2;
  assign bus.y_im      = y_im_p2;
  assign bus.addrA_out = addr_a_p2;
  assign bus.addrB_out = addr_b_p2;
  assign bus.we_ram1   = we1_p2;
  assign bus.we_ram2   = we2_p2;
  assign bus.done_out  = done_p2;
  assign bus.ovf       = ovf_p2;

endmodule

// File: tb/tb_fft_bfly.sv
// Directed bench for fft_bfly with hand-computed butterfly results.
module tb_fft_bfly;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fft_bfly_if #(.DW(16), .AW(6)) bus ();

  fft_bfly #(.DW(16), .AW(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
    bus.w_re = '0; bus.w_im = '0;
    bus.addrA_in = '0; bus.addrB_in = '0;
    bus.wr_sel = 1'b0; bus.last_in = 1'b0; bus.scale = 1'b0;
  endtask

  task automatic issue(input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi, input logic sc,
                       input int aa, input int ab, input logic ws, input logic lst);
    bus.in_valid = 1'b1;
    bus.a_re = 16'(ar); bus.a_im = 16'(ai);
    bus.b_re = 16'(br); bus.b_im = 16'(bi);
    bus.w_re = 16'(wr); bus.w_im = 16'(wi);
    bus.scale = sc;
    bus.addrA_in = 6'(aa); bus.addrB_in = 6'(ab);
    bus.wr_sel = ws; bus.last_in = lst;
  endtask

  // Issue one butterfly and return at the negedge after its result edge
  task automatic single(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input logic sc,
                        input int aa, input int ab, input logic ws, input logic lst);
    @(negedge clk);
    issue(ar, ai, br, bi, wr, wi, sc, aa, ab, ws, lst);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.ovf_clr = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we1", bus.we_ram1, 0);
    chk("rst_we2", bus.we_ram2, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_xre", bus.x_re, 0);
    reset_n = 1'b1;

    single(1000, 0, 500, 0, 32767, 0, 1'b0, 5, 6, 1'b0, 1'b0);
    chk("t1_xre", bus.x_re, 1500);
    chk("t1_xim", bus.x_im, 0);
    chk("t1_yre", bus.y_re, 500);
    chk("t1_yim", bus.y_im, 0);
    chk("t1_we1", bus.we_ram1, 1);
    chk("t1_we2", bus.we_ram2, 0);
    chk("t1_addra", bus.addrA_out, 5);
    chk("t1_addrb", bus.addrB_out, 6);
    chk("t1_done", bus.done_out, 0);
    @(negedge clk);
    chk("hold_xre", bus.x_re, 1500);
    chk("hold_addra", bus.addrA_out, 5);
    chk("hold_we1", bus.we_ram1, 0);
    chk("t1_ovf", bus.ovf, 0);

    single(1000, 0, 500, 0, 32767, 0, 1'b1, 7, 8, 1'b1, 1'b1);
    chk("sc_xre", bus.x_re, 750);
    chk("sc_yre", bus.y_re, 250);
    chk("sc_xim", bus.x_im, 0);
    chk("sc_we1", bus.we_ram1, 0);
    chk("sc_we2", bus.we_ram2, 1);
    chk("sc_addrb", bus.addrB_out, 8);
    chk("sc_done", bus.done_out, 1);
    @(negedge clk);
    chk("sc_done_pulse", bus.done_out, 0);
    chk("sc_we2_off", bus.we_ram2, 0);

    single(0, 0, 100, 0, 0, -32768, 1'b0, 1, 2, 1'b0, 1'b0);
    chk("t2_xre", bus.x_re, 0);
    chk("t2_xim", bus.x_im, -100);
    chk("t2_yre", bus.y_re, 0);
    chk("t2_yim", bus.y_im, 100);
    @(negedge clk);
    chk("t2_ovf", bus.ovf, 0);

    single(32767, 0, 32767, 0, 32767, 0, 1'b0, 3, 4, 1'b0, 1'b0);
    chk("t3_xre", bus.x_re, 32767);
    chk("t3_xim", bus.x_im, 0);
    chk("t3_yre", bus.y_re, 1);
    chk("t3_yim", bus.y_im, 0);
    @(negedge clk);
    chk("t3_ovf_set", bus.ovf, 1);
    repeat (4) @(negedge clk);
    chk("t3_ovf_sticky", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf, 0);

    // Negative saturation while ovf_clr is held: set must win
    bus.ovf_clr = 1'b1;
    single(-32768, 0, -32768, 0, -32768, 0, 1'b0, 9, 10, 1'b0, 1'b0);
    chk("neg_xre", bus.x_re, 0);
    chk("neg_yre", bus.y_re, -32768);
    @(negedge clk);
    chk("set_beats_clr", bus.ovf, 1);
    bus.ovf_clr = 1'b0;

    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      if (c >= 3 && c < 35) begin
        int j;
        j = c - 3;
        chk("bst_we1", bus.we_ram1, ((j / 8) % 2 == 0) ? 1 : 0);
        chk("bst_we2", bus.we_ram2, ((j / 8) % 2 == 1) ? 1 : 0);
        chk("bst_addra", bus.addrA_out, 2 * j);
        chk("bst_addrb", bus.addrB_out, 2 * j + 1);
        chk("bst_done", bus.done_out, (j == 31) ? 1 : 0);
        chk("bst_xre", bus.x_re, 10 * j + 1);
        chk("bst_yim", bus.y_im, -j);
      end else begin
        chk("bst_idle_we1", bus.we_ram1, 0);
        chk("bst_idle_we2", bus.we_ram2, 0);
        chk("bst_idle_done", bus.done_out, 0);
      end
      if (c < 32)
        issue(10 * c + 1, -c, 0, 0, 0, 0, 1'b0, 2 * c, 2 * c + 1,
              ((c / 8) % 2) == 1, c == 31);
      else
        bus.in_valid = 1'b0;
    end

    // Async reset with two butterflies in flight
    @(negedge clk);
    issue(1200, 5, 300, 0, 32767, 0, 1'b0, 11, 12, 1'b0, 1'b1);
    @(negedge clk);
    issue(1300, 6, 300, 0, 32767, 0, 1'b0, 13, 14, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_xre", bus.x_re, 0);
    chk("arst_yim", bus.y_im, 0);
    chk("arst_addra", bus.addrA_out, 0);
    chk("arst_addrb", bus.addrB_out, 0);
    chk("arst_ovf", bus.ovf, 0);
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_we1", bus.we_ram1, 0);
      chk("post_we2", bus.we_ram2, 0);
      chk("post_done", bus.done_out, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
